// File: rtl/oam_dma.sv
// OAM DMA engine: on a CPU write to the trigger address it halts the CPU and
// copies one 256-byte page of CPU memory into the PPU OAMDATA register.
module oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
  parameter logic [2:0]  OAMDATA_REG  = 3'h4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr_i,
  input  logic        cpu_wr_i,
  input  logic [7:0]  cpu_data_i,
  output logic        dma_halt,
  output logic        dma_busy,
  output logic [15:0] mem_addr_o,
  output logic        mem_rd,
  input  logic [7:0]  mem_data_i,
  output logic        ppu_cs,
  output logic        ppu_rw,
  output logic [2:0]  ppu_addr_o,
  output logic [7:0]  ppu_data_o
);

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  idx_q, idx_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic        cyc_odd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      page_q     <= 8'h00;
      idx_q      <= 8'h00;
      mem_addr_q <= 16'h0000;
      cyc_odd_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      page_q     <= page_d;
      idx_q      <= idx_d;
      mem_addr_q <= mem_addr_d;
      cyc_odd_q  <= ~cyc_odd_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    page_d     = page_q;
    idx_d      = idx_q;
    mem_addr_d = mem_addr_q;
    dma_halt   = 1'b1;
    mem_rd     = 1'b0;
    mem_addr_o = mem_addr_q;
    ppu_cs     = 1'b0;
    ppu_rw     = 1'b1;
    ppu_addr_o = 3'h0;
    ppu_data_o = 8'h00;

    unique case (state_q)
      IDLE: begin
        dma_halt = 1'b0;
        if (cpu_wr_i && (cpu_addr_i == DMA_REG_ADDR)) begin
          page_d  = cpu_data_i;
          idx_d   = 8'h00;
          state_d = HALT;
        end
      end
      // An odd cycle here costs one extra ALIGN cycle before the first read.
      HALT:  state_d = cyc_odd_q ? ALIGN : READ;
      ALIGN: state_d = READ;
      READ: begin
        mem_rd     = 1'b1;
        mem_addr_d = {page_q, idx_q};
        mem_addr_o = mem_addr_d;
        state_d    = WRITE;
      end
      WRITE: begin
        ppu_cs     = 1'b1;
        ppu_rw     = 1'b0;
        ppu_addr_o = OAMDATA_REG;
        ppu_data_o = mem_data_i;
        idx_d      = idx_q + 8'd1;
        state_d    = (idx_q == 8'hFF) ? IDLE : READ;
      end
      default: begin
        dma_halt = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  assign dma_busy = dma_halt;

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: table of transfers checked cycle by cycle against a
// bench-side schedule, with a scoreboard of expected OAMDATA bytes.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu_addr_i = 16'h0000;
  logic        cpu_wr_i = 1'b0;
  logic [7:0]  cpu_data_i = 8'h00;
  logic        dma_halt, dma_busy, mem_rd, ppu_cs, ppu_rw;
  logic [15:0] mem_addr_o;
  logic [7:0]  mem_data_i, ppu_data_o;
  logic [2:0]  ppu_addr_o;

  logic [7:0]  mem [0:65535];
  logic [7:0]  memData = 8'h00;
  logic [7:0]  oam [0:255];
  logic [7:0]  sbq [$];
  logic        par;
  int          vectors = 0;
  int          miscompares = 0;

  typedef struct {
    logic [7:0] page;
    bit         oddPar;
    int         expHalt;
    int         expFirst;
    int         injectAt;
    int         abortAt;
  } vec_t;

  vec_t tbl [7];

  oam_dma dut (
    .clk(clk), .rst(rst),
    .cpu_addr_i(cpu_addr_i), .cpu_wr_i(cpu_wr_i), .cpu_data_i(cpu_data_i),
    .dma_halt(dma_halt), .dma_busy(dma_busy),
    .mem_addr_o(mem_addr_o), .mem_rd(mem_rd), .mem_data_i(mem_data_i),
    .ppu_cs(ppu_cs), .ppu_rw(ppu_rw), .ppu_addr_o(ppu_addr_o), .ppu_data_o(ppu_data_o)
  );

  always #5 clk = ~clk;

  // One-cycle-latency memory and a bench copy of the bus-cycle parity.
  always @(posedge clk) if (mem_rd) memData <= mem[mem_addr_o];
  assign mem_data_i = memData;

  always @(posedge clk or posedge rst) begin
    if (rst) par <= 1'b0;
    else     par <= ~par;
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] data);
    cpu_wr_i   = 1'b1;
    cpu_addr_i = addr;
    cpu_data_i = data;
    @(negedge clk);
    cpu_wr_i   = 1'b0;
    cpu_addr_i = 16'h0000;
    cpu_data_i = 8'h00;
  endtask

  task automatic alignParity(input bit oddPar);
    @(negedge clk);
    for (int k = 0; k < 4 && par == oddPar; k++) @(negedge clk);
  endtask

  task automatic pushExpected(input logic [7:0] pg);
    for (int i = 0; i < 256; i++) sbq.push_back(mem[{pg, 8'(i)}]);
  endtask

  task automatic runTransfer(input vec_t v);
    int oamAddr = 0;
    for (int c = 1; c <= v.expHalt + 1; c++) begin
      bit expRd, expWr;
      expRd = (c >= v.expFirst) && (c <= v.expHalt) && ((c - v.expFirst) % 2 == 0);
      expWr = (c > v.expFirst) && (c <= v.expHalt) && ((c - v.expFirst) % 2 == 1);
      checkOutput("dma_halt", dma_halt, int'(c <= v.expHalt));
      checkOutput("dma_busy", dma_busy, int'(c <= v.expHalt));
      checkOutput("mem_rd", mem_rd, int'(expRd));
      checkOutput("ppu_cs", ppu_cs, int'(expWr));
      if (expRd) checkOutput("mem_addr_o", mem_addr_o, {v.page, 8'((c - v.expFirst) / 2)});
      if (expWr) begin
        checkOutput("sb_depth", sbq.size(), 256 - oamAddr);
        if (sbq.size() > 0) checkOutput("ppu_data_o", ppu_data_o, sbq.pop_front());
        checkOutput("ppu_rw", ppu_rw, 0);
        checkOutput("ppu_addr_o", ppu_addr_o, 4);
        oam[oamAddr[7:0]] = ppu_data_o;
        oamAddr++;
      end else begin
        checkOutput("ppu_rw_idle", ppu_rw, 1);
        checkOutput("ppu_data_idle", ppu_data_o, 0);
      end
      if (c == v.injectAt) begin
        cpu_wr_i = 1'b1; cpu_addr_i = 16'h4014; cpu_data_i = 8'h03;
      end
      if (c == v.injectAt + 1) begin
        cpu_wr_i = 1'b0; cpu_addr_i = 16'h0000; cpu_data_i = 8'h00;
      end
      if (c == v.abortAt) begin
        #1 rst = 1'b1;
        #1;
        checkOutput("abort_halt", dma_halt, 0);
        checkOutput("abort_busy", dma_busy, 0);
        checkOutput("abort_mem_rd", mem_rd, 0);
        checkOutput("abort_ppu_cs", ppu_cs, 0);
        checkOutput("abort_mem_addr", mem_addr_o, 0);
        checkOutput("abort_ppu_rw", ppu_rw, 1);
        sbq.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (c <= v.expHalt) @(negedge clk);
    end
    checkOutput("sb_leftover", sbq.size(), 0);
    checkOutput("oam_writes", oamAddr, 256);
    for (int i = 0; i < 256; i++) checkOutput("oam_readback", oam[i], mem[{v.page, 8'(i)}]);
  endtask

  initial begin
    logic [15:0] otherAddr [3];
    for (int a = 0; a < 65536; a++) begin
      logic [15:0] av;
      av = 16'(a);
      mem[a] = av[7:0] ^ 8'h5A ^ ((av[15:8] == 8'h02) ? 8'h00 : av[15:8]);
    end
    tbl[0] = '{8'h02, 1'b0, 513, 2, -10, -10};
    tbl[1] = '{8'h02, 1'b1, 514, 3, -10, -10};
    tbl[2] = '{8'hFF, 1'b0, 513, 2, -10, -10};
    tbl[3] = '{8'h02, 1'b0, 513, 2, 100, -10};
    tbl[4] = '{8'h02, 1'b1, 514, 3, -10, 300};
    tbl[5] = '{8'h02, 1'b0, 513, 2, -10, -10};
    tbl[6] = '{8'hFF, 1'b1, 514, 3, -10, -10};
    otherAddr[0] = 16'h4013;
    otherAddr[1] = 16'h4015;
    otherAddr[2] = 16'h2004;

    repeat (2) @(negedge clk);
    checkOutput("rst_halt", dma_halt, 0);
    checkOutput("rst_busy", dma_busy, 0);
    checkOutput("rst_mem_rd", mem_rd, 0);
    checkOutput("rst_mem_addr", mem_addr_o, 0);
    checkOutput("rst_ppu_cs", ppu_cs, 0);
    checkOutput("rst_ppu_rw", ppu_rw, 1);
    checkOutput("rst_ppu_addr", ppu_addr_o, 0);
    checkOutput("rst_ppu_data", ppu_data_o, 0);
    rst = 1'b0;

    // Writes to neighbouring registers must not start anything.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      applyStimulus(otherAddr[k], 8'h02);
      for (int n = 0; n < 4; n++) begin
        checkOutput("nontrig_busy", dma_busy, 0);
        checkOutput("nontrig_mem_rd", mem_rd, 0);
        checkOutput("nontrig_ppu_cs", ppu_cs, 0);
        @(negedge clk);
      end
    end

    for (int t = 0; t < 7; t++) begin
      alignParity(tbl[t].oddPar);
      pushExpected(tbl[t].page);
      applyStimulus(16'h4014, tbl[t].page);
      runTransfer(tbl[t]);
      $display("[TB] transfer %0d page %02h done", t, tbl[t].page);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- CPU-side bus initiator that bulk-loads sprite OAM through the PPU register port. It drives the same cpu_cs/cpu_rw/cpu_addr/cpu_data_i interface that the ppu module receives.
- A CPU write to the DMA trigger address starts a transfer. The block halts the CPU, reads 256 bytes from page {P,8'h00} of CPU memory, and writes each byte to PPU register OAMDATA.
- Sits between the CPU core, CPU memory map and the ppu instance in the top level.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address whose write triggers DMA (data byte = source page P).
- OAMDATA_REG, 3'h4, PPU register index written for each byte.

Ports:
- clk  in  1  system clock; every clk is one CPU bus cycle.
- rst  in  1  asynchronous, active-high reset.
- cpu_addr_i  in  16  CPU bus address (snooped).
- cpu_wr_i  in  1  CPU write strobe (snooped).
- cpu_data_i  in  8  CPU write data (snooped).
- dma_halt  out  1  stalls the CPU while high.
- dma_busy  out  1  transfer in progress (any state except IDLE).
- mem_addr_o  out  16  DMA source address.
- mem_rd  out  1  DMA memory read strobe.
- mem_data_i  in  8  memory read data; valid the cycle after mem_rd (1-cycle latency).
- ppu_cs  out  1  PPU register chip select.
- ppu_rw  out  1  PPU read/write; 0 = write.
- ppu_addr_o  out  3  PPU register index.
- ppu_data_o  out  8  PPU write data.

Behaviour:
- Reset: all state and outputs clear asynchronously. dma_halt=0, dma_busy=0, mem_rd=0, mem_addr_o=0, ppu_cs=0, ppu_rw=1, ppu_addr_o=0, ppu_data_o=0, page=0, idx=0, cyc_odd=0, state=IDLE.
- cyc_odd is a parity flop that toggles every clk from reset, independent of DMA.
- Trigger: in IDLE, a rising edge with cpu_wr_i=1 and cpu_addr_i==DMA_REG_ADDR latches page<=cpu_data_i and idx<=0, then enters HALT.
  - Writes to any other address do nothing.
  - A trigger while dma_busy=1 is ignored; page is not reloaded.
- HALT (1 cycle): dma_halt=1, no bus activity. Next state is ALIGN if cyc_odd==1 in this cycle, otherwise READ.
- ALIGN (1 cycle): dma_halt=1, no bus activity, next state READ.
- READ: dma_halt=1, mem_rd=1, mem_addr_o={page,idx}, ppu_cs=0. Next state WRITE.
- WRITE: dma_halt=1, mem_rd=0, ppu_cs=1, ppu_rw=0, ppu_addr_o=OAMDATA_REG, ppu_data_o=mem_data_i (combinational passthrough; the PPU samples it on the edge that ends WRITE).
  - idx increments mod 256.
  - If idx was 8'hFF, next state is IDLE; otherwise READ.
- Address generation never carries out of the page: page FF reads FF00..FFFF only.
- Outside WRITE: ppu_cs=0, ppu_rw=1, ppu_data_o=0. Outside READ: mem_rd=0, and mem_addr_o holds its last value.
- Timing: dma_halt rises the cycle after the trigger edge and falls on the edge ending the last WRITE.
  - Total halted cycles: 513 with even parity, 514 with odd.
  - Exactly 256 PPU writes, in idx order 00..FF.
- dma_busy == dma_halt in every cycle.
- Reset mid-transfer aborts immediately to IDLE with all outputs at reset values. A partially written OAM is accepted; no resume.
- The CPU write that triggers the DMA is never forwarded to the PPU by this block.

Test Plan:
- Memory 0x0200+i = i^8'h5A; trigger write $4014<=8'h02 with cyc_odd=0 -> dma_halt high exactly 513 cycles. 256 ppu_cs writes with ppu_addr_o=4, ppu_rw=0, ppu_data_o sequence 5A,5B,58,... matching mem[0x0200+i]. PPU OAM readback (OAMADDR=0) matches.
- Same trigger issued one cycle later (cyc_odd=1 in HALT) -> 514 halted cycles, one idle ALIGN cycle before the first mem_rd, data identical.
- Trigger $4014<=8'hFF -> mem_addr_o spans FF00..FFFF, never 0000 or 0100. dma_busy drops after the 256th write.
- Second write $4014<=8'h03 at transfer cycle 100 -> ignored: page stays 02, total writes still 256, halt length unchanged.
- Assert rst at transfer cycle 300 -> same-cycle asynchronous clear: dma_halt=0, ppu_cs=0, mem_rd=0. A new trigger after reset starts cleanly from idx 0.
- Writes to $4013, $4015 and $2004 -> no dma_busy, no mem_rd, no ppu_cs activity from this block.
